// File: rtl/restoring_divider.sv
// restoring_divider: 8-bit sequential restoring divider, quotient in B and remainder in A.
// Define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands.
module restoring_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearA_loadB,
  input  logic       execute,
  input  logic [7:0] sw,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       done,
  output logic       busy,
  output logic       div_zero
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, SUB, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [2:0] cnt_q, cnt_d;
  logic dz_q, dz_d;
  logic [8:0] t;
`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic sa_q, sa_d, sb_q, sb_d;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    cnt_d = cnt_q;
    dz_d = dz_q;
    t = {1'b0, a_q} - {1'b0, m_q};
`ifdef RESTORING_DIVIDER_SIGNED_EN
    sa_d = sa_q;
    sb_d = sb_q;
`endif
    case (state_q)
      IDLE: begin
        if (clearA_loadB) state_d = LOAD;
        else if (execute) begin
          state_d = SETUP;
          m_d = sw;
        end
      end
      LOAD: begin
        b_d = sw;
        a_d = 8'd0;
        dz_d = 1'b0;
        state_d = IDLE;
      end
      SETUP: begin
        if (m_q == 8'd0) begin
          b_d = 8'hFF;
          a_d = b_q;
          dz_d = 1'b1;
          state_d = DONE;
        end else begin
          a_d = 8'd0;
          cnt_d = 3'd0;
          dz_d = 1'b0;
          state_d = SHIFT;
`ifdef RESTORING_DIVIDER_SIGNED_EN
          // -128 negates to 8'h80, which the unsigned core reads as 128
          sa_d = b_q[7];
          sb_d = m_q[7];
          b_d = b_q[7] ? 8'd0 - b_q : b_q;
          m_d = m_q[7] ? 8'd0 - m_q : m_q;
`endif
        end
      end
      SHIFT: begin
        {a_d, b_d} = {a_q, b_q} << 1;
        state_d = SUB;
      end
      SUB: begin
        a_d = t[8] ? a_q : t[7:0];
        b_d[0] = ~t[8];
        state_d = (cnt_q == 3'd7) ? FIX : SHIFT;
        cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
      end
      FIX: begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
        b_d = (sa_q ^ sb_q) ? 8'd0 - b_q : b_q;
        a_d = sa_q ? 8'd0 - a_q : a_q;
`endif
        state_d = DONE;
      end
      DONE: state_d = execute ? DONE : (clearA_loadB ? LOAD : IDLE);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= 8'd0;
      b_q <= 8'd0;
      m_q <= 8'd0;
      cnt_q <= 3'd0;
      dz_q <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      sa_q <= 1'b0;
      sb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      dz_q <= dz_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      sa_q <= sa_d;
      sb_q <= sb_d;
`endif
    end
  end
  assign Aval = a_q;
  assign Bval = b_q;
  assign done = state_q == DONE;
  assign busy = state_q inside {SETUP, SHIFT, SUB, FIX};
  assign div_zero = dz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors for restoring_divider with hand-computed results.
module tb_restoring_divider;
  logic clk, reset, clearA_loadB, execute;
  logic [7:0] sw, Aval, Bval;
  logic done, busy, div_zero;
  int vecs = 0, errs = 0;
  int cyc;

  restoring_divider dut (
    .clk(clk), .reset(reset), .clearA_loadB(clearA_loadB), .execute(execute),
    .sw(sw), .Aval(Aval), .Bval(Bval), .done(done), .busy(busy), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    sw = v;
    clearA_loadB = 1'b1;
    step();
    clearA_loadB = 1'b0;
    step();
  endtask

  // edge 0 is the first edge seeing execute; returns the edge index where done rises, -1 on timeout
  task automatic run(input logic [7:0] d, output int c);
    c = -1;
    sw = d;
    execute = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      sw = 8'h33;
      clearA_loadB = (n == 3 || n == 4);
      if (done) begin
        c = n;
        break;
      end
    end
    clearA_loadB = 1'b0;
  endtask

  task automatic release_exec();
    execute = 1'b0;
    step();
  endtask

  task automatic div(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                     input logic [7:0] q, input logic [7:0] r, input int lat);
    load(dd);
    chk({tag, "_load"}, Bval, dd);
    run(dv, cyc);
    chk({tag, "_lat"}, cyc[15:0], lat[15:0]);
    chk({tag, "_q"}, Bval, q);
    chk({tag, "_r"}, Aval, r);
    chk({tag, "_dz"}, div_zero, dv == 8'd0);
    release_exec();
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    clearA_loadB = 1'b0;
    execute = 1'b0;
    sw = 8'h00;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();
    chk("rst_A", Aval, 8'h00);
    chk("rst_B", Bval, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dz", div_zero, 1'b0);

    load(8'hC8);
    chk("load_A", Aval, 8'h00);
    chk("load_B", Bval, 8'hC8);
    run(8'h07, cyc);
    chk("u200_lat", cyc[15:0], 16'd18);
    chk("u200_q", Bval, 8'h1C);
    chk("u200_r", Aval, 8'h04);
    chk("u200_dz", div_zero, 1'b0);
    repeat (40) step();
    chk("hold_done", done, 1'b1);
    chk("hold_busy", busy, 1'b0);
    chk("hold_q", Bval, 8'h1C);
    chk("hold_r", Aval, 8'h04);
    release_exec();
    chk("drop_done", done, 1'b0);
    chk("drop_busy", busy, 1'b0);
    chk("drop_B", Bval, 8'h1C);

    div("dz", 8'h55, 8'h00, 8'hFF, 8'h55, 1);
    div("max", 8'hFF, 8'h01, 8'hFF, 8'h00, 18);
    div("small", 8'h05, 8'h09, 8'h00, 8'h05, 18);
`ifdef RESTORING_DIVIDER_SIGNED_EN
    div("s_m7d2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 18);
    div("s_wrap", 8'h80, 8'hFF, 8'h80, 8'h00, 18);
    div("s_p7dm2", 8'h07, 8'hFE, 8'hFD, 8'h01, 18);
`else
    div("u_249d2", 8'hF9, 8'h02, 8'h7C, 8'h01, 18);
    div("u_100d10", 8'h64, 8'h0A, 8'h0A, 8'h00, 18);
    div("u_128d3", 8'h80, 8'h03, 8'h2A, 8'h02, 18);
`endif

    load(8'h64);
    sw = 8'h0A;
    execute = 1'b1;
    for (int n = 0; n <= 9; n++) step();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    execute = 1'b0;
    #1;
    chk("mid_rst_A", Aval, 8'h00);
    chk("mid_rst_B", Bval, 8'h00);
    chk("mid_rst_flags", {done, busy, div_zero}, 3'b000);
    #2 reset = 1'b0;
    step();
    chk("mid_idle", {done, busy}, 2'b00);
    div("after_rst", 8'h64, 8'h0A, 8'h0A, 8'h00, 18);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
